// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - funct3 codes, FSM state type and branch decision helper
//
// Purpose: types and helpers shared by branch_comp_seq and its bench.
// Contents:
//   F3_*            RV32 branch funct3 encodings
//   state_e         compare FSM states IDLE / CMP / DONE
//   branch_taken()  branch decision from funct3 and the eq/lt result
//   funct3_illegal() funct3 values that are not branch encodings (010, 011)
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       eq,
                                          input logic       lt);
        logic taken;
        case (funct3)
            F3_BEQ:           taken = eq;
            F3_BNE:           taken = ~eq;
            F3_BLT, F3_BLTU:  taken = lt;
            F3_BGE, F3_BGEU:  taken = ~lt;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic logic funct3_illegal(input logic [2:0] funct3);
        return (funct3[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// rtl/chunk_cmp.sv - combinational unsigned compare of one CHUNK-bit slice
//
// Purpose: per-cycle slice comparator used by branch_comp_seq.
// Ports:
//   a_i, b_i  CHUNK-bit unsigned slices
//   ne_o      slices differ
//   lt_o      a_i < b_i (unsigned)
module chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             ne_o,
    output logic             lt_o
);

    assign ne_o = (a_i != b_i);
    assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/branch_comp_seq.sv
// rtl/branch_comp_seq.sv - multi-cycle MSB-first chunked branch comparator
//
// Purpose: compares two WIDTH-bit operands CHUNK bits per cycle, most
// significant chunk first, stopping at the first differing chunk, and
// resolves eq/lt plus the RV32 branch decision from funct3.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush_i             synchronous abort, highest priority
//   req_valid_i/req_ready_o, a_i, b_i, funct3_i   request channel
//   resp_valid_o/resp_ready_i, eq_o, lt_o, taken_o, illegal_o  response channel
module branch_comp_seq
    import branch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       funct3_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             eq_o,
    output logic             lt_o,
    output logic             taken_o,
    output logic             illegal_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("branch_comp_seq: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       f3_q, f3_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             taken_q, taken_d;
    logic             illegal_q, illegal_d;

    // Flipping the MSB of both operands maps signed order onto unsigned
    // order, so the chunk comparator only ever needs unsigned compares.
    logic [WIDTH-1:0] sign_bias;
    assign sign_bias = {~funct3_i[1], {(WIDTH-1){1'b0}}};

    // Chunk 0 is the most significant slice.
    logic [CHUNK-1:0] a_chunk [NCHUNK];
    logic [CHUNK-1:0] b_chunk [NCHUNK];
    for (genvar i = 0; i < NCHUNK; i++) begin : g_chunks
        assign a_chunk[i] = a_q[WIDTH-1-i*CHUNK -: CHUNK];
        assign b_chunk[i] = b_q[WIDTH-1-i*CHUNK -: CHUNK];
    end

    logic [CHUNK-1:0] a_sel, b_sel;
    logic             chunk_ne, chunk_lt, last_chunk;
    assign a_sel      = a_chunk[k_q];
    assign b_sel      = b_chunk[k_q];
    assign last_chunk = (k_q == KW'(NCHUNK - 1));

    chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .a_i  (a_sel),
        .b_i  (b_sel),
        .ne_o (chunk_ne),
        .lt_o (chunk_lt)
    );

    assign req_ready_o  = (state_q == IDLE) & ~flush_i;
    assign resp_valid_o = (state_q == DONE);
    assign eq_o         = eq_q;
    assign lt_o         = lt_q;
    assign taken_o      = taken_q;
    assign illegal_o    = illegal_q;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        f3_d      = f3_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;

        if (flush_i) begin
            state_d = IDLE;
            k_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        state_d = CMP;
                        k_d     = '0;
                        a_d     = a_i ^ sign_bias;
                        b_d     = b_i ^ sign_bias;
                        f3_d    = funct3_i;
                    end
                end
                CMP: begin
                    if (chunk_ne || last_chunk) begin
                        // Result registers only move here, so they stay put
                        // through DONE and beyond until the next result.
                        state_d   = DONE;
                        k_d       = '0;
                        eq_d      = ~chunk_ne;
                        lt_d      = chunk_ne & chunk_lt;
                        taken_d   = branch_taken(f3_q, ~chunk_ne, chunk_ne & chunk_lt);
                        illegal_d = funct3_illegal(f3_q);
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                DONE: begin
                    if (resp_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            f3_q      <= '0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            a_q       <= a_d;
            b_q       <= b_d;
            f3_q      <= f3_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_branch_comp_seq.sv
// tb/tb_branch_comp_seq.sv - self-checking bench for branch_comp_seq
module tb_branch_comp_seq;

    localparam int W   = 32;
    localparam int CH  = 8;
    localparam int NCH = W / CH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic [2:0]    funct3_i = 3'b000;
    logic          resp_valid_o;
    logic          resp_ready_i = 1'b1;
    logic          eq_o, lt_o, taken_o, illegal_o;

    always #5 clk = ~clk;

    branch_comp_seq #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .a_i          (a_i),
        .b_i          (b_i),
        .funct3_i     (funct3_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .eq_o         (eq_o),
        .lt_o         (lt_o),
        .taken_o      (taken_o),
        .illegal_o    (illegal_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the full operands.
    logic exp_active = 1'b0;
    logic m_eq, m_lt, m_taken, m_ill;
    int   m_len;

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f3);
        logic [W-1:0] ca, cb;
        m_eq  = (a == b);
        m_lt  = f3[1] ? (a < b) : ($signed(a) < $signed(b));
        m_ill = (f3 == 3'b010) || (f3 == 3'b011);
        case (f3)
            3'b000:         m_taken = m_eq;
            3'b001:         m_taken = !m_eq;
            3'b100, 3'b110: m_taken = m_lt;
            3'b101, 3'b111: m_taken = !m_lt;
            default:        m_taken = 1'b0;
        endcase
        m_len = NCH;
        for (int i = NCH - 1; i >= 0; i--) begin
            ca = (a >> (W - CH * (i + 1))) & ((1 << CH) - 1);
            cb = (b >> (W - CH * (i + 1))) & ((1 << CH) - 1);
            if (ca != cb) m_len = i + 1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid_o) begin
            check("resp_expected", exp_active, 1);
            check("eq_model", eq_o, m_eq);
            check("lt_model", lt_o, m_lt);
            check("taken_model", taken_o, m_taken);
            check("illegal_model", illegal_o, m_ill);
        end
    end

    typedef struct {
        logic [2:0]   f3;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         eq;
        logic         lt;
        logic         taken;
        logic         ill;
        int           len;
    } vec_t;

    vec_t vecs[10];

    task automatic run_op(input vec_t v, input bit hold);
        int n;
        bit found;
        @(negedge clk);
        a_i = v.a; b_i = v.b; funct3_i = v.f3;
        req_valid_i = 1'b1;
        resp_ready_i = !hold;
        #1 check("req_ready_idle", req_ready_o, 1);
        @(posedge clk);
        model(v.a, v.b, v.f3);
        exp_active = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        n = 0;
        found = 0;
        while (!found && n < NCH + 3) begin
            @(posedge clk);
            #1;
            n++;
            found = resp_valid_o;
        end
        if (!found) begin
            check("resp_timeout", 0, 1);
            exp_active = 1'b0;
            resp_ready_i = 1'b1;
            return;
        end
        check("latency", n, v.len);
        check("latency_model", n, m_len);
        check("eq_lit", eq_o, v.eq);
        check("lt_lit", lt_o, v.lt);
        check("taken_lit", taken_o, v.taken);
        check("illegal_lit", illegal_o, v.ill);
        if (hold) begin
            repeat (5) begin
                @(negedge clk);
                check("hold_valid", resp_valid_o, 1);
                check("hold_eq", eq_o, v.eq);
                check("hold_lt", lt_o, v.lt);
                check("hold_taken", taken_o, v.taken);
                check("hold_illegal", illegal_o, v.ill);
            end
            @(negedge clk);
            resp_ready_i = 1'b1;
        end
        @(posedge clk);
        exp_active = 1'b0;
        #1 check("resp_consumed", resp_valid_o, 0);
    endtask

    initial begin
        //          f3      a             b             eq lt tk il len
        vecs[0] = '{3'b100, 32'hFFFFFFFF, 32'h00000001, 0, 1, 1, 0, 1};
        vecs[1] = '{3'b110, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0, 1};
        vecs[2] = '{3'b000, 32'h12345678, 32'h12345678, 1, 0, 1, 0, 4};
        vecs[3] = '{3'b101, 32'h00000100, 32'h000000FF, 0, 0, 1, 0, 3};
        vecs[4] = '{3'b111, 32'h80000000, 32'h7FFFFFFF, 0, 0, 1, 0, 1};
        vecs[5] = '{3'b100, 32'h80000000, 32'h7FFFFFFF, 0, 1, 1, 0, 1};
        vecs[6] = '{3'b001, 32'h00000000, 32'h00000000, 1, 0, 0, 0, 4};
        vecs[7] = '{3'b010, 32'h00000003, 32'h80000000, 0, 1, 0, 1, 1};
        vecs[8] = '{3'b001, 32'h00000005, 32'h00000006, 0, 1, 1, 0, 4};
        vecs[9] = '{3'b011, 32'h000000AB, 32'h000000AB, 1, 0, 0, 1, 4};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", resp_valid_o, 0);
        check("rst_eq", eq_o, 0);
        check("rst_lt", lt_o, 0);
        check("rst_taken", taken_o, 0);
        check("rst_illegal", illegal_o, 0);
        rst = 1'b0;
        #1 check("ready_after_rst", req_ready_o, 1);

        // Directed vectors; BEQ equal one held in DONE for 5 cycles
        for (int i = 0; i < 8; i++) run_op(vecs[i], (i == 2));

        // Flush on the 2nd CMP cycle of a 4-cycle compare
        @(negedge clk);
        a_i = 32'h12345678; b_i = 32'h12345678; funct3_i = 3'b000;
        req_valid_i = 1'b1;
        @(posedge clk);
        model(a_i, b_i, funct3_i);
        exp_active = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        exp_active = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        check("flush_no_valid", resp_valid_o, 0);
        check("flush_ready", req_ready_o, 1);
        repeat (NCH + 2) begin
            @(negedge clk);
            check("flush_stays_quiet", resp_valid_o, 0);
        end
        run_op(vecs[8], 0);

        // Request presented alongside flush is not taken
        @(negedge clk);
        a_i = '0; b_i = '0; funct3_i = 3'b000;
        req_valid_i = 1'b1;
        flush_i = 1'b1;
        #1 check("flush_blocks_ready", req_ready_o, 0);
        @(negedge clk);
        req_valid_i = 1'b0;
        flush_i = 1'b0;
        repeat (NCH + 2) begin
            @(negedge clk);
            check("flush_req_dropped", resp_valid_o, 0);
        end
        check("ready_after_drop", req_ready_o, 1);

        // Leave nonzero results behind, then reset mid-CMP
        run_op(vecs[9], 0);
        @(negedge clk);
        a_i = 32'h12345678; b_i = 32'h12345678; funct3_i = 3'b000;
        req_valid_i = 1'b1;
        @(posedge clk);
        model(a_i, b_i, funct3_i);
        exp_active = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_active = 1'b0;
        #1;
        check("midrst_valid", resp_valid_o, 0);
        check("midrst_eq", eq_o, 0);
        check("midrst_lt", lt_o, 0);
        check("midrst_taken", taken_o, 0);
        check("midrst_illegal", illegal_o, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_ready", req_ready_o, 1);
        repeat (NCH + 2) begin
            @(negedge clk);
            check("midrst_no_resp", resp_valid_o, 0);
        end
        run_op(vecs[3], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_comp_seq.md
Name: branch_comp_seq

Overview:
Parametrised, multi-cycle successor to the single-cycle branch comparator. It compares two WIDTH-bit operands CHUNK bits per cycle, from the most significant chunk down, and terminates early at the first differing chunk. It resolves eq/lt and the RV32 branch decision from funct3. The block sits beside the execute stage and serves the long-operand / low-area configurations through a valid/ready request–response handshake.

Parameters:
WIDTH, 32, operand width in bits
CHUNK, 8, bits compared per cycle; WIDTH % CHUNK == 0 is required (elaboration error otherwise); CHUNK == WIDTH gives single-cycle compare
NCHUNK, WIDTH/CHUNK, derived localparam, not overridable

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
flush_i  in  1  synchronous abort of any in-flight compare
req_valid_i  in  1  request valid
req_ready_o  out  1  block can accept a request
a_i  in  WIDTH  operand rs1
b_i  in  WIDTH  operand rs2
funct3_i  in  3  branch funct3, captured with the request
resp_valid_o  out  1  result valid
resp_ready_i  in  1  consumer accepts result
eq_o  out  1  a == b
lt_o  out  1  a < b, signed or unsigned per funct3[1]
taken_o  out  1  branch taken
illegal_o  out  1  funct3 is 010 or 011

Behaviour:
- Reset (async, asserted): state IDLE; resp_valid_o, eq_o, lt_o, taken_o and illegal_o all 0; chunk index 0. req_ready_o is 1 as soon as rst deasserts, provided flush_i is 0.
- States and transitions:
  - IDLE -> CMP on accept, i.e. req_valid_i & req_ready_o.
  - CMP -> DONE when the current chunk differs or the last chunk has been evaluated.
  - DONE -> IDLE on resp_valid_o & resp_ready_i.
- req_ready_o = (state == IDLE) & ~flush_i, combinational. No acceptance in the DONE-handshake cycle, so peak throughput is one op per latency + 2 cycles.
- On accept, register the operands and funct3.
  - Unsigned select u = funct3[1].
  - If ~u, invert bit WIDTH-1 of both registered operands (sign-bias). All later compares are unsigned.
- CMP: each cycle evaluates chunk k (k = 0 is bits WIDTH-1 : WIDTH-CHUNK).
  - Chunks differ: lt = (a_chunk < b_chunk), eq = 0, go to DONE.
  - Chunks equal and k == NCHUNK-1: eq = 1, lt = 0, go to DONE.
  - Otherwise k++ and stay in CMP.
- Latency: resp_valid_o rises L edges after the accept edge. L = 1 + index of the first differing chunk, or L = NCHUNK if a == b. Range 1..NCHUNK.
- Branch decision, taken_o by funct3:
  - 000: eq
  - 001: ~eq
  - 100 and 110: lt
  - 101 and 111: ~lt
  - 010 and 011: taken_o = 0, illegal_o = 1; eq_o and lt_o are still computed, unsigned.
- DONE: all outputs are held stable while resp_ready_i is low. Outputs only change when the next result is produced.
- flush_i is synchronous and takes priority over everything else.
  - Any state goes to IDLE at the next edge; k is cleared; resp_valid_o is 0 in the next cycle.
  - A pending result is discarded.
  - A request presented in the same cycle as flush_i is not accepted.
- rst asserted mid-operation: immediate return to reset values; no response is produced.

Decomposition:
- Package branch_pkg:
  - funct3 localparams (F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU)
  - state enum {IDLE, CMP, DONE}
  - helper function branch_taken(funct3, eq, lt)
- One sub-module, chunk_cmp: combinational, CHUNK-bit unsigned compare producing ne and lt. It is instantiated once and fed by a mux on k.

Test Plan:
1. WIDTH 32, CHUNK 8; BLT, a = 0xFFFFFFFF, b = 0x00000001 -> lt = 1, eq = 0, taken = 1, L = 1.
2. BLTU with the same operands -> lt = 0, taken = 0, L = 1.
3. BEQ, a = b = 0x12345678 -> eq = 1, lt = 0, taken = 1, L = 4.
4. BGE, a = 0x00000100, b = 0x000000FF -> first difference in chunk 2; L = 3, lt = 0, taken = 1.
5. BEQ equal operands, flush_i on the 2nd CMP cycle -> no resp_valid; req_ready = 1 next cycle. Next request BNE 5 vs 6 -> taken = 1. Also: req_valid together with flush_i -> not accepted.
6. resp_ready held low 5 cycles in DONE -> all outputs stable. Separately: funct3 = 010 -> illegal = 1, taken = 0. rst pulsed mid-CMP -> all outputs 0 immediately.
